// File: rtl/bin_to_seg_digits_if.sv
// Display-value bus between a value producer and bin_to_seg_digits.
// master drives the value and the load request; slave returns status and segment patterns.
interface bin_to_seg_digits_if #(
   parameter int CONV_BITS = 14
);
   logic [CONV_BITS-1:0] value_i;
   logic                 load_i;
   logic                 busy_o;
   logic                 done_o;
   logic [6:0]           seg_a_o;
   logic [6:0]           seg_b_o;
   logic [6:0]           seg_c_o;
   logic [6:0]           seg_d_o;

   modport master (
      output value_i, load_i,
      input  busy_o, done_o, seg_a_o, seg_b_o, seg_c_o, seg_d_o
   );

   modport slave (
      input  value_i, load_i,
      output busy_o, done_o, seg_a_o, seg_b_o, seg_c_o, seg_d_o
   );
endinterface

// File: rtl/bin_to_seg_digits.sv
// Binary-to-four-digit 7-segment converter using a one-bit-per-clock double-dabble engine.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (units digit is always shown).
//
// state  | meaning
// IDLE   | waiting for load_i; segment outputs hold the last result
// SHIFT  | one add-3/shift step per clock, CONV_BITS steps in total
// UPDATE | encode BCD (or dashes on overflow) into segments, pulse done_o
module bin_to_seg_digits #(
   parameter int CONV_BITS = 14,
   parameter int MAX_VALUE = 9999
) (
   input  logic             clk_25MHz,
   input  logic             reset_n,
   bin_to_seg_digits_if.slave bus
);
   localparam int                   CW      = $clog2(CONV_BITS);
   localparam logic [CONV_BITS-1:0] MAX_V   = CONV_BITS'(MAX_VALUE);
   localparam logic [6:0]           SEG_DASH  = 7'h3F;
   localparam logic [6:0]           SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_UPDATE} state_t;

   state_t               state_q, state_d;
   logic [CONV_BITS-1:0] bin_q, bin_d;
   logic [15:0]          bcd_q, bcd_d, bcd_adj;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [6:0]           seg_a_q, seg_a_d, seg_b_q, seg_b_d;
   logic [6:0]           seg_c_q, seg_c_d, seg_d_q, seg_d_d;
   logic                 blank_a, blank_b, blank_c;

   function automatic logic [6:0] seg_of(input logic [3:0] nib);
      case (nib)
         4'd0:    seg_of = 7'h40;
         4'd1:    seg_of = 7'h79;
         4'd2:    seg_of = 7'h24;
         4'd3:    seg_of = 7'h30;
         4'd4:    seg_of = 7'h19;
         4'd5:    seg_of = 7'h12;
         4'd6:    seg_of = 7'h02;
         4'd7:    seg_of = 7'h78;
         4'd8:    seg_of = 7'h00;
         4'd9:    seg_of = 7'h10;
         default: seg_of = SEG_BLANK;
      endcase
   endfunction

   // Add-3 is confined to each nibble; carries never propagate between digits.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 4; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      blank_a = 1'b0;
      blank_b = 1'b0;
      blank_c = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank_a = (bcd_q[15:12] == 4'd0);
      blank_b = blank_a && (bcd_q[11:8] == 4'd0);
      blank_c = blank_b && (bcd_q[7:4] == 4'd0);
`else
`endif
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      seg_a_d = seg_a_q;
      seg_b_d = seg_b_q;
      seg_c_d = seg_c_q;
      seg_d_d = seg_d_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.load_i) begin
               bin_d   = bus.value_i;
               bcd_d   = '0;
               cnt_d   = CW'(CONV_BITS - 1);
               ovf_d   = (bus.value_i > MAX_V);
               busy_d  = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            bcd_d = {bcd_adj[14:0], bin_q[CONV_BITS-1]};
            bin_d = {bin_q[CONV_BITS-2:0], 1'b0};
            if (cnt_q == '0)
               state_d = ST_UPDATE;
            else
               cnt_d = cnt_q - CW'(1);
         end
         ST_UPDATE: begin
            if (ovf_q) begin
               seg_a_d = SEG_DASH;
               seg_b_d = SEG_DASH;
               seg_c_d = SEG_DASH;
               seg_d_d = SEG_DASH;
            end else begin
               seg_a_d = blank_a ? SEG_BLANK : seg_of(bcd_q[15:12]);
               seg_b_d = blank_b ? SEG_BLANK : seg_of(bcd_q[11:8]);
               seg_c_d = blank_c ? SEG_BLANK : seg_of(bcd_q[7:4]);
               seg_d_d = seg_of(bcd_q[3:0]);
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_25MHz or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         seg_a_q <= SEG_BLANK;
         seg_b_q <= SEG_BLANK;
         seg_c_q <= SEG_BLANK;
         seg_d_q <= SEG_BLANK;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         seg_a_q <= seg_a_d;
         seg_b_q <= seg_b_d;
         seg_c_q <= seg_c_d;
         seg_d_q <= seg_d_d;
      end
   end

   assign bus.busy_o  = busy_q;
   assign bus.done_o  = done_q;
   assign bus.seg_a_o = seg_a_q;
   assign bus.seg_b_o = seg_b_q;
   assign bus.seg_c_o = seg_c_q;
   assign bus.seg_d_o = seg_d_q;
endmodule

// File: tb/tb_bin_to_seg_digits.sv
// Directed self-checking bench for bin_to_seg_digits; expectations follow LEADING_ZERO_BLANK_EN.
module tb_bin_to_seg_digits;
   logic clk_25MHz = 1'b0;
   logic reset_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   bin_to_seg_digits_if #(.CONV_BITS(14)) bus_if();

   bin_to_seg_digits #(.CONV_BITS(14), .MAX_VALUE(9999)) dut (
      .clk_25MHz (clk_25MHz),
      .reset_n   (reset_n),
      .bus       (bus_if)
   );

   always #20 clk_25MHz = ~clk_25MHz;

   localparam logic [27:0] SEGS_BLANK = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
   localparam logic [27:0] SEGS_DASH  = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
   localparam logic [27:0] SEGS_1234  = {7'h79, 7'h24, 7'h30, 7'h19};
   localparam logic [27:0] SEGS_9999  = {7'h10, 7'h10, 7'h10, 7'h10};
   localparam logic [27:0] SEGS_5678  = {7'h12, 7'h02, 7'h78, 7'h00};
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [27:0] SEGS_42    = {7'h7F, 7'h7F, 7'h19, 7'h24};
   localparam logic [27:0] SEGS_0     = {7'h7F, 7'h7F, 7'h7F, 7'h40};
`else
   localparam logic [27:0] SEGS_42    = {7'h40, 7'h40, 7'h19, 7'h24};
   localparam logic [27:0] SEGS_0     = {7'h40, 7'h40, 7'h40, 7'h40};
`endif

   function automatic logic [27:0] segs();
      return {bus_if.seg_a_o, bus_if.seg_b_o, bus_if.seg_c_o, bus_if.seg_d_o};
   endfunction

   task automatic tick();
      @(posedge clk_25MHz);
      #1;
   endtask

   task automatic start_load(input logic [13:0] v);
      bus_if.value_i = v;
      bus_if.load_i  = 1'b1;
      tick();
      bus_if.load_i  = 1'b0;
   endtask

   task automatic wait_done(output int cycles);
      cycles = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (bus_if.done_o === 1'b1) begin
            cycles = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bus_if.load_i  = 1'b0;
      bus_if.value_i = '0;
      reset_n = 1'b1;
      #3 reset_n = 1'b0;
      #2;
      n_tests++;
      if (segs() !== SEGS_BLANK) begin
         n_fail++;
         $display("FAIL reset_segs: got %h expected %h", segs(), SEGS_BLANK);
      end
      n_tests++;
      if (bus_if.busy_o !== 1'b0 || bus_if.done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got busy=%b done=%b expected 0 0", bus_if.busy_o, bus_if.done_o);
      end
      @(negedge clk_25MHz);
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_nominal();
      int c;
      start_load(14'd1234);
      n_tests++;
      if (bus_if.busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL nominal_busy_set: got %b expected 1", bus_if.busy_o);
      end
      wait_done(c);
      n_tests++;
      if (c != 15) begin
         n_fail++;
         $display("FAIL nominal_latency: got %0d expected 15", c);
      end
      n_tests++;
      if (segs() !== SEGS_1234) begin
         n_fail++;
         $display("FAIL nominal_segs: got %h expected %h", segs(), SEGS_1234);
      end
      n_tests++;
      if (bus_if.busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL nominal_busy_clear: got %b expected 0", bus_if.busy_o);
      end
      tick();
      n_tests++;
      if (bus_if.done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL nominal_done_width: got %b expected 0", bus_if.done_o);
      end
   endtask

   task automatic test_leading_zeros();
      logic [13:0] vals [2];
      logic [27:0] exps [2];
      int c;
      vals[0] = 14'd42; exps[0] = SEGS_42;
      vals[1] = 14'd0;  exps[1] = SEGS_0;
      for (int i = 0; i < 2; i++) begin
         start_load(vals[i]);
         wait_done(c);
         n_tests++;
         if (c != 15) begin
            n_fail++;
            $display("FAIL lz_latency[%0d]: got %0d expected 15", vals[i], c);
         end
         n_tests++;
         if (segs() !== exps[i]) begin
            n_fail++;
            $display("FAIL lz_segs[%0d]: got %h expected %h", vals[i], segs(), exps[i]);
         end
      end
   endtask

   task automatic test_boundaries();
      logic [13:0] vals [3];
      logic [27:0] exps [3];
      int c;
      vals[0] = 14'd9999;  exps[0] = SEGS_9999;
      vals[1] = 14'd10000; exps[1] = SEGS_DASH;
      vals[2] = 14'd16383; exps[2] = SEGS_DASH;
      for (int i = 0; i < 3; i++) begin
         start_load(vals[i]);
         wait_done(c);
         n_tests++;
         if (c != 15) begin
            n_fail++;
            $display("FAIL bound_latency[%0d]: got %0d expected 15", vals[i], c);
         end
         n_tests++;
         if (segs() !== exps[i]) begin
            n_fail++;
            $display("FAIL bound_segs[%0d]: got %h expected %h", vals[i], segs(), exps[i]);
         end
      end
   endtask

   task automatic test_busy_ignore();
      int c;
      int pulses;
      start_load(14'd5678);
      repeat (4) tick();
      n_tests++;
      if (segs() !== SEGS_DASH) begin
         n_fail++;
         $display("FAIL busy_hold_segs: got %h expected %h", segs(), SEGS_DASH);
      end
      bus_if.value_i = 14'd1111;
      bus_if.load_i  = 1'b1;
      tick();
      bus_if.load_i  = 1'b0;
      wait_done(c);
      n_tests++;
      if (c != 10) begin
         n_fail++;
         $display("FAIL busy_latency: got %0d expected 10", c);
      end
      n_tests++;
      if (segs() !== SEGS_5678) begin
         n_fail++;
         $display("FAIL busy_segs: got %h expected %h", segs(), SEGS_5678);
      end
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus_if.done_o === 1'b1) pulses++;
      end
      n_tests++;
      if (pulses != 0 || segs() !== SEGS_5678) begin
         n_fail++;
         $display("FAIL busy_no_second: got pulses=%0d segs=%h expected 0 %h", pulses, segs(), SEGS_5678);
      end
   endtask

   task automatic test_back_to_back();
      logic [13:0] vals [4];
      logic [27:0] exps [4];
      int c;
      vals[0] = 14'd42;    exps[0] = SEGS_42;
      vals[1] = 14'd9999;  exps[1] = SEGS_9999;
      vals[2] = 14'd10000; exps[2] = SEGS_DASH;
      vals[3] = 14'd1234;  exps[3] = SEGS_1234;
      bus_if.load_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus_if.value_i = vals[i];
         tick();
         bus_if.value_i = 14'd7777;
         n_tests++;
         if (bus_if.busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept[%0d]: got busy=%b expected 1", i, bus_if.busy_o);
         end
         wait_done(c);
         n_tests++;
         if (c != 15) begin
            n_fail++;
            $display("FAIL b2b_latency[%0d]: got %0d expected 15", i, c);
         end
         n_tests++;
         if (segs() !== exps[i]) begin
            n_fail++;
            $display("FAIL b2b_segs[%0d]: got %h expected %h", i, segs(), exps[i]);
         end
      end
      bus_if.load_i = 1'b0;
      tick();
      n_tests++;
      if (bus_if.busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_idle_after: got busy=%b expected 0", bus_if.busy_o);
      end
   endtask

   task automatic test_reset_mid_shift();
      int pulses;
      int c;
      start_load(14'd1234);
      repeat (4) tick();
      #5 reset_n = 1'b0;
      #1;
      n_tests++;
      if (segs() !== SEGS_BLANK) begin
         n_fail++;
         $display("FAIL midrst_segs: got %h expected %h", segs(), SEGS_BLANK);
      end
      n_tests++;
      if (bus_if.busy_o !== 1'b0 || bus_if.done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_flags: got busy=%b done=%b expected 0 0", bus_if.busy_o, bus_if.done_o);
      end
      repeat (2) tick();
      @(negedge clk_25MHz);
      reset_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (bus_if.done_o === 1'b1) pulses++;
      end
      n_tests++;
      if (pulses != 0 || segs() !== SEGS_BLANK || bus_if.busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_no_done: got pulses=%0d segs=%h busy=%b expected 0 %h 0",
                  pulses, segs(), bus_if.busy_o, SEGS_BLANK);
      end
      start_load(14'd5678);
      wait_done(c);
      n_tests++;
      if (c != 15 || segs() !== SEGS_5678) begin
         n_fail++;
         $display("FAIL midrst_recover: got lat=%0d segs=%h expected 15 %h", c, segs(), SEGS_5678);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_leading_zeros();
      test_boundaries();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_shift();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/bin_to_seg_digits.md
# bin_to_seg_digits

Converts a 14-bit unsigned binary value (0–9999) into four decimal digits and drives the four 7-bit segment patterns consumed by the board's four-digit multiplexed display driver. Conversion is sequential: a shift-and-add-3 (double-dabble) engine performs one bit per clock. Finished patterns are held in registers until the next accepted load. The block sits directly upstream of the display multiplexer. Its segment outputs connect one-to-one to that driver's four digit inputs.

## Interface
Parameters:
- `CONV_BITS`, 14: input value width; also the number of shift cycles per conversion.
- `MAX_VALUE`, 9999: largest displayable value; anything above it is shown as overflow.

Ports:
- `clk_25MHz` input 1: 25 MHz system clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `value_i` input 14: unsigned binary value to display; sampled only on an accepted load.
- `load_i` input 1: request a conversion; accepted only when `busy_o`=0.
- `busy_o` output 1: conversion in progress; registered.
- `done_o` output 1: one-cycle pulse when new patterns are written; registered.
- `seg_a_o` output 7: thousands digit, leftmost display.
- `seg_b_o` output 7: hundreds digit.
- `seg_c_o` output 7: tens digit.
- `seg_d_o` output 7: units digit, rightmost display.

Segment encoding for all four outputs:
- Bit order `{g,f,e,d,c,b,a}` (bit 0 = a); active-low, 0 = segment lit.
- Digits 0–9: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10 (hex).
- Dash: 3F. Blank: 7F.

## Operation
FSM states: IDLE, SHIFT, UPDATE.
- **IDLE**
  - On `load_i`=1: capture `value_i` into a 14-bit shift register, clear the 16-bit BCD register, and set the shift counter to 13.
  - Also capture an overflow flag = (`value_i` > `MAX_VALUE`).
  - Go to SHIFT.
- **SHIFT**
  - Each cycle, every BCD nibble ≥ 5 gets +3 (all four nibbles evaluated in parallel, before the shift).
  - Then shift `{bcd, bin}` left by 1.
  - Arithmetic is 4-bit per nibble; add-3 never carries between nibbles.
  - When the counter reaches 0, after performing that shift, go to UPDATE. Otherwise decrement the counter.
- **UPDATE**
  - Encode the BCD nibbles into `seg_a_o`..`seg_d_o`.
  - If the overflow flag is set, drive all four outputs to dash (3F) instead.
  - Pulse `done_o`. Go to IDLE.

Rules:
- `load_i` while busy: ignored, not queued. The in-flight conversion is unaffected.
- `value_i` changes after capture have no effect on the in-flight conversion.
- Segment outputs change only in UPDATE. Between conversions they hold their last values, so the downstream multiplexer never sees partial digits.
- Overflow always runs the full 14 shift cycles, so latency is uniform.
- The nibble ≥ 10 condition is impossible for values ≤ 9999. For values > 9999 the BCD content is don't-care, because the outputs are dashes.

## Timing
- Reset values: `seg_*_o` = 7F (blank), `busy_o`=0, `done_o`=0, FSM = IDLE, internal registers = 0.
- Load accepted at rising edge N:
  - `busy_o`=1 after edge N.
  - Shifts occur at edges N+1 through N+14.
  - UPDATE executes at edge N+15: new segment values and `done_o`=1 are visible after N+15, and `busy_o`=0 after N+15.
  - `done_o` returns to 0 after N+16.
- Load-to-output latency: 15 cycles (600 ns).
- Earliest next accepted load: edge N+16.
- Back-to-back throughput: one conversion per 16 cycles.
- `reset_n` asserted at any point, including mid-SHIFT or during UPDATE:
  - The conversion is aborted and all outputs immediately return to reset values.
  - No `done_o` pulse is produced.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - In UPDATE, leading zero digits are driven blank (7F), scanning from `seg_a_o` toward `seg_c_o`.
  - `seg_d_o` is never blanked; value 0 shows blank, blank, blank, 0.
  - The overflow dash display is unaffected.
- Not defined: all four digits are always shown, including leading zeros (for example, 42 shows 0042).
- Latency and handshake are identical in both builds.

## Test plan
- **Reset:** assert `reset_n`=0 mid-SHIFT after loading 1234 → outputs immediately 7F/7F/7F/7F; `busy_o`=0; no `done_o` pulse after reset is released.
- **Nominal:** load 1234 at edge N → `done_o` high after N+15; outputs 79/24/30/19; `busy_o` low after N+15.
- **Leading zeros:** load 42 → without the macro 40/40/19/24; with the macro 7F/7F/19/24. Load 0 with the macro → 7F/7F/7F/40.
- **Boundaries:** load 9999 → 10/10/10/10. Load 10000 and 16383 → 3F/3F/3F/3F, both with 15-cycle latency.
- **Busy ignore:** load 5678, then pulse `load_i` with 1111 at N+5 → result 12/02/78/00 at N+15; no second `done_o` pulse.
- **Back-to-back:** hold `load_i`=1 continuously while `value_i` changes → conversions accepted every 16 cycles; each `done_o` pulse matches the value captured at its accept edge.
